// File: rtl/cam_search_ctrl.sv
// cam_search_ctrl
//   CAM storage and search stage feeding the CAM output multiplexer.
//   Holds ENTRIES tag/data/valid entries with write, single-entry invalidate
//   and global flush. Searches use a valid/ready handshake with a 1-cycle
//   registered result (hit flag + lowest matching index).
//
// Optional feature: define CAM_MULTI_HIT_EN to add multi_hit_o, which flags
//   two or more valid matches for the accepted tag.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   we_i, write_index_i,
//   write_tag_i, write_data_i  entry write
//   inval_i, inval_index_i   single-entry invalidate (tag/data retained)
//   flush_i                  clear all valid bits
//   search_valid_i, search_tag_i, search_ready_o   search request
//   result_valid_o, result_ready_i                 result handshake
//   hit_o, read_address_o    registered result
//   data_array_o             flattened payloads, entry i at [i*DATA_W +: DATA_W]
//   multi_hit_o              (CAM_MULTI_HIT_EN only) registered multi-match flag
//
// Output state machine:
//   state | meaning
//   EMPTY | no result held, result_valid_o=0
//   FULL  | result held until consumed, result_valid_o=1

module cam_search_ctrl #(
    parameter int ENTRIES = 32,
    parameter int TAG_W   = 32,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic [IDX_W-1:0]          write_index_i,
    input  logic [TAG_W-1:0]          write_tag_i,
    input  logic [DATA_W-1:0]         write_data_i,
    input  logic                      inval_i,
    input  logic [IDX_W-1:0]          inval_index_i,
    input  logic                      flush_i,
    input  logic                      search_valid_i,
    input  logic [TAG_W-1:0]          search_tag_i,
    output logic                      search_ready_o,
    output logic                      result_valid_o,
    input  logic                      result_ready_i,
    output logic                      hit_o,
    output logic [IDX_W-1:0]          read_address_o,
    output logic [ENTRIES*DATA_W-1:0] data_array_o
`ifdef CAM_MULTI_HIT_EN
    ,
    output logic                      multi_hit_o
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [DATA_W-1:0]  data_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q;

    logic [ENTRIES-1:0] match;
    logic [IDX_W-1:0]   match_idx;
    logic               any_match;
    logic               accept;

    // Storage. The strobe is tested before the index so an X index with its
    // strobe low cannot disturb any entry. A write wins over flush/invalidate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (we_i && (write_index_i == IDX_W'(i))) begin
                    valid_q[i] <= 1'b1;
                    tag_q[i]   <= write_tag_i;
                    data_q[i]  <= write_data_i;
                end else if (flush_i) begin
                    valid_q[i] <= 1'b0;
                end else if (inval_i && (inval_index_i == IDX_W'(i))) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_data_out
        assign data_array_o[g*DATA_W +: DATA_W] = data_q[g];
    end

    // Compare against registered contents, so same-cycle updates are not seen.
    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == search_tag_i);
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                match_idx = IDX_W'(i);
            end
        end
    end

    assign any_match = |match;

    assign result_valid_o = (state_q == FULL);
    assign search_ready_o = !result_valid_o || result_ready_i;
    assign accept         = search_valid_i && search_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (result_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Result only loads on an accepted search, so a held result never
    // reflects later storage changes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_o          <= 1'b0;
            read_address_o <= '0;
        end else if (accept) begin
            hit_o          <= any_match;
            read_address_o <= match_idx;
        end
    end

`ifdef CAM_MULTI_HIT_EN
    // Clearing the lowest set bit leaves something only if two or more matched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            multi_hit_o <= 1'b0;
        end else if (accept) begin
            multi_hit_o <= |(match & (match - ENTRIES'(1)));
        end
    end
`endif

endmodule

// File: doc/cam_search_ctrl.md
Name: cam_search_ctrl

Overview:
- CAM storage and search stage that sits directly upstream of the CAM output multiplexer.
- Holds ENTRIES tag/data/valid entries, accepts writes, single-entry invalidates, a global flush and search requests.
- Searches use a valid/ready handshake and return a registered hit flag and a matching index.
- Exports the full flattened data array and the matching index, which together drive the multiplexer's data and read-address inputs.

Parameters:
- ENTRIES, 32, number of CAM entries.
- TAG_W, 32, search/tag width in bits.
- DATA_W, 32, payload width per entry in bits.
- IDX_W, 5, entry index width; must equal log2(ENTRIES).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- we_i  in  1  write strobe.
- write_index_i  in  IDX_W  entry to write.
- write_tag_i  in  TAG_W  tag to store.
- write_data_i  in  DATA_W  payload to store.
- inval_i  in  1  invalidate strobe.
- inval_index_i  in  IDX_W  entry to invalidate.
- flush_i  in  1  clear all valid bits.
- search_valid_i  in  1  search request valid.
- search_tag_i  in  TAG_W  tag to look up.
- search_ready_o  out  1  search request can be accepted.
- result_valid_o  out  1  result register holds an unconsumed result.
- result_ready_i  in  1  downstream consumes the result.
- hit_o  out  1  registered hit flag.
- read_address_o  out  IDX_W  registered matching index; goes to the multiplexer read address.
- data_array_o  out  ENTRIES*DATA_W  flattened stored payloads; entry i occupies bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (rst_ni low, asynchronous):
  - all valid bits, tags and payloads are 0;
  - result_valid_o=0, hit_o=0, read_address_o=0.
- Writes and invalidates:
  - Write: when we_i=1, entry write_index_i takes tag, data and valid=1 on the next edge.
  - Invalidate: when inval_i=1, valid[inval_index_i] is 0 on the next edge. Tag and data are retained.
  - Priority, highest first: we_i, then flush_i, then inval_i. An entry being written ends valid even if a flush or invalidate hits the same entry in that cycle.
- data_array_o is driven straight from the storage registers and shows a new value the cycle after the write.
- Search handshake:
  - search_ready_o = !result_valid_o || result_ready_i.
  - A search is accepted when search_valid_i && search_ready_o.
  - Compare covers valid entries only, using contents before any same-cycle write, invalidate or flush (read-before-write).
- Search result:
  - Latency is 1 cycle: accepted at edge N, result registered at edge N+1.
  - Hit: hit_o=1 and read_address_o = lowest matching index (priority encode).
  - Miss: hit_o=0 and read_address_o=0.
- Output state machine, two states:
  - EMPTY (result_valid_o=0): an accepted search goes to FULL.
  - FULL (result_valid_o=1):
    - result_ready_i=1 with a new accepted search: reload and stay FULL;
    - result_ready_i=1 with no search: go to EMPTY;
    - result_ready_i=0: hold hit_o and read_address_o stable.
- A held result is not re-evaluated. Later writes or flushes do not change hit_o or read_address_o.
- Back-to-back: one search per cycle is sustained when result_ready_i stays 1.
- X on write_index_i or inval_index_i while the matching strobe is low has no effect.

Optional Feature:
- Macro: CAM_MULTI_HIT_EN.
- When defined:
  - adds output port multi_hit_o (1 bit), registered with the result;
  - multi_hit_o=1 when two or more valid entries match the accepted tag;
  - it is held under backpressure like hit_o and resets to 0;
  - read_address_o is still the lowest matching index.
- When not defined: the port is absent and duplicate matches resolve silently to the lowest index.

Test Plan:
- Reset then search tag 0xDEADBEEF with result_ready_i=1 -> next cycle result_valid_o=1, hit_o=0, read_address_o=0.
- Write index 7 with tag 0x1234 and data 0xCAFE0007, then search 0x1234 -> hit_o=1, read_address_o=7, and data_array_o[7*32 +: 32]=0xCAFE0007.
- Write tag 0xAA to indices 3 and 20, then search 0xAA -> read_address_o=3. With CAM_MULTI_HIT_EN defined, multi_hit_o=1 as well.
- Hold result_ready_i=0 for 4 cycles after a hit on index 7 while search_valid_i=1 -> search_ready_o=0, outputs held at 1/7, no new search accepted. Raising result_ready_i accepts the pending search the same cycle.
- Write index 9 with tag 0x55 and search 0x55 in the same cycle -> miss. A repeat search -> hit at 9. Then flush_i, then search 0x55 -> miss.
- Assert rst_ni low mid-stream while result_valid_o=1 -> immediately result_valid_o=0, hit_o=0, and all entries invalid on the next search.
